multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM for a multicycle MIPS-style datapath.
//               Sequences FETCH / DECODE and the per-class execute and
//               write-back steps, and decodes every datapath control strobe
//               combinationally from the current state (plus opcode_reg and
//               zero where a state needs them).
//
//   Ports
//     clk          in   rising-edge clock
//     reset        in   asynchronous, active-low reset
//     opcode_reg   in   [5:0] instruction-register opcode
//     zero         in   ALU zero flag
//     flag_R_type  in   decoder R-type class flag (steers DECODE)
//     flag_I_type  in   decoder I-type class flag (not used for steering)
//     flag_J_type  in   decoder J-type class flag (not used for steering)
//     pc_en        out  PC load strobe
//     IorD         out  memory address select (0 = PC, 1 = ALUOut)
//     MemWrite     out  memory write strobe
//     IRWrite      out  instruction register load
//     RegWrite     out  register file write strobe
//     MemtoReg     out  write-back select (1 = MDR)
//     ALUSrcA      out  ALU A select (0 = PC, 1 = register A)
//     ALUSrcB      out  [1:0] ALU B select (B / 4 / sext imm / imm<<2)
//     PCSrc        out  [1:0] PC source (ALU result / ALUOut / jump target)
//     link_sel     out  write PC into $31 (jal link)
//     illegal_op   out  one-cycle pulse on an unrecognised opcode
//     state        out  [3:0] current state encoding (debug)
//     instr_done   out  one-cycle pulse on the last cycle of an instruction
//
//   Compile-time option
//     JAL_LINK_EN  when defined, jal also writes the return address ($31)
//                  during JUMP; otherwise jal behaves exactly like j.
//
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode_reg,
    input  logic       zero,
    input  logic       flag_R_type,
    input  logic       flag_I_type,
    input  logic       flag_J_type,
    output logic       pc_en,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       link_sel,
    output logic       illegal_op,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [3:0] state,
    output logic       instr_done
);

    // State encodings are architecturally visible on the debug port.
    localparam logic [3:0] c_FETCH     = 4'd0;
    localparam logic [3:0] c_DECODE    = 4'd1;
    localparam logic [3:0] c_MEM_ADR   = 4'd2;
    localparam logic [3:0] c_MEM_READ  = 4'd3;
    localparam logic [3:0] c_MEM_WB    = 4'd4;
    localparam logic [3:0] c_MEM_WRITE = 4'd5;
    localparam logic [3:0] c_EXECUTE   = 4'd6;
    localparam logic [3:0] c_ALU_WB    = 4'd7;
    localparam logic [3:0] c_IMM_EXEC  = 4'd8;
    localparam logic [3:0] c_IMM_WB    = 4'd9;
    localparam logic [3:0] c_BRANCH    = 4'd10;
    localparam logic [3:0] c_JUMP      = 4'd11;

    localparam logic [5:0] c_OP_LW   = 6'h23;
    localparam logic [5:0] c_OP_SW   = 6'h2B;
    localparam logic [5:0] c_OP_ADDI = 6'h08;
    localparam logic [5:0] c_OP_ANDI = 6'h0C;
    localparam logic [5:0] c_OP_ORI  = 6'h0D;
    localparam logic [5:0] c_OP_LUI  = 6'h0F;
    localparam logic [5:0] c_OP_BEQ  = 6'h04;
    localparam logic [5:0] c_OP_BNE  = 6'h05;
    localparam logic [5:0] c_OP_J    = 6'h02;
    localparam logic [5:0] c_OP_JAL  = 6'h03;

    logic [3:0] r_state;
    logic [3:0] w_next_state;

    // Opcode classes. Loads/stores are recognised from the opcode alone:
    // the decoder's own class flags mark lui as a store, so they cannot be
    // trusted for memory steering, and the I/J flags are not consulted.
    logic w_op_mem;
    logic w_op_imm;
    logic w_op_branch;
    logic w_op_jump;
    logic w_decode_illegal;
    logic w_branch_taken;
    logic w_unused_flags;

    assign w_op_mem    = (opcode_reg == c_OP_LW) || (opcode_reg == c_OP_SW);
    assign w_op_imm    = (opcode_reg == c_OP_ADDI) || (opcode_reg == c_OP_ANDI) ||
                         (opcode_reg == c_OP_ORI)  || (opcode_reg == c_OP_LUI);
    assign w_op_branch = (opcode_reg == c_OP_BEQ) || (opcode_reg == c_OP_BNE);
    assign w_op_jump   = (opcode_reg == c_OP_J)   || (opcode_reg == c_OP_JAL);

    assign w_decode_illegal = !(w_op_mem || flag_R_type || w_op_imm ||
                                w_op_branch || w_op_jump);

    assign w_branch_taken = ((opcode_reg == c_OP_BEQ) &&  zero) ||
                            ((opcode_reg == c_OP_BNE) && !zero);

    assign w_unused_flags = flag_I_type | flag_J_type;

    // ------------------------------------------------------------------
    // Next-state logic. Terminal states and the unused encodings 12-15
    // all fall through to FETCH via the default arm.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = c_FETCH;
        case (r_state)
            c_FETCH:    w_next_state = c_DECODE;
            c_DECODE: begin
                if (w_op_mem)         w_next_state = c_MEM_ADR;
                else if (flag_R_type) w_next_state = c_EXECUTE;
                else if (w_op_imm)    w_next_state = c_IMM_EXEC;
                else if (w_op_branch) w_next_state = c_BRANCH;
                else if (w_op_jump)   w_next_state = c_JUMP;
                else                  w_next_state = c_FETCH;
            end
            c_MEM_ADR:  w_next_state = (opcode_reg == c_OP_LW) ? c_MEM_READ : c_MEM_WRITE;
            c_MEM_READ: w_next_state = c_MEM_WB;
            c_EXECUTE:  w_next_state = c_ALU_WB;
            c_IMM_EXEC: w_next_state = c_IMM_WB;
            default:    w_next_state = c_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Output decode. The whole decode is gated by reset so that the
    // FETCH strobes (IRWrite, pc_en) stay low while the block is held in
    // reset, and an asynchronous reset kills any in-flight write at once.
    // ------------------------------------------------------------------
    always_comb begin
        pc_en      = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        link_sel   = 1'b0;
        illegal_op = 1'b0;
        ALUSrcB    = 2'd0;
        PCSrc      = 2'd0;
        instr_done = 1'b0;
        if (reset) begin
            case (r_state)
                c_FETCH: begin
                    IRWrite = 1'b1;
                    pc_en   = 1'b1;
                    ALUSrcB = 2'd1;
                end
                c_DECODE: begin
                    // Branch target (PC + imm<<2) is computed speculatively.
                    ALUSrcB    = 2'd3;
                    illegal_op = w_decode_illegal;
                    instr_done = w_decode_illegal;
                end
                c_MEM_ADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                end
                c_MEM_READ: begin
                    IorD = 1'b1;
                end
                c_MEM_WB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                c_MEM_WRITE: begin
                    IorD       = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                c_EXECUTE: begin
                    ALUSrcA = 1'b1;
                end
                c_ALU_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                c_IMM_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                end
                c_IMM_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                c_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    PCSrc      = 2'd1;
                    pc_en      = w_branch_taken;
                    instr_done = 1'b1;
                end
                c_JUMP: begin
                    pc_en      = 1'b1;
                    PCSrc      = 2'd2;
                    instr_done = 1'b1;
`ifdef JAL_LINK_EN
                    if (opcode_reg == c_OP_JAL) begin
                        RegWrite = 1'b1;
                        link_sel = 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire
